// File: rtl/bck_ctx_sched_pkg.sv
// rtl/bck_ctx_sched_pkg.sv - shared status tokens and context state encoding for the backward scheduler
package bck_pkg;

    localparam logic [5:0] F_init  = 6'h00;
    localparam logic [5:0] F_run   = 6'h01;
    localparam logic [5:0] F_break = 6'h02;
    localparam logic [5:0] BCK_INI = 6'h04;
    localparam logic [5:0] BCK_RUN = 6'h05;
    localparam logic [5:0] BCK_END = 6'h06;
    localparam logic [5:0] BUBBLE  = 6'h30;
    localparam logic [5:0] DONE    = 6'h20;

    typedef enum logic [2:0] {
        CS_IDLE    = 3'd0,
        CS_RDY_INI = 3'd1,
        CS_WAIT_FB = 3'd2,
        CS_RDY_RUN = 3'd3,
        CS_RDY_END = 3'd4
    } ctx_state_t;

    function automatic logic is_ready(input ctx_state_t s);
        return (s == CS_RDY_INI) || (s == CS_RDY_RUN) || (s == CS_RDY_END);
    endfunction

    function automatic logic [5:0] token_of(input ctx_state_t s);
        case (s)
            CS_RDY_INI: return BCK_INI;
            CS_RDY_RUN: return BCK_RUN;
            CS_RDY_END: return BCK_END;
            default:    return BUBBLE;
        endcase
    endfunction

endpackage

// File: rtl/bck_ctx_sched_rr_pick.sv
// rtl/bck_ctx_sched_rr_pick.sv - combinational round-robin picker over an eligibility vector
// Ports:
//   elig  : one bit per context, 1 = candidate
//   ptr   : index where the search starts (tie to 0 for fixed lowest-index priority)
//   found : some candidate exists
//   idx   : first candidate at or after ptr, wrapping modulo N
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            // N is a power of two, so the W-bit add wraps exactly modulo N
            cand = ptr + W'(i);
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bck_ctx_sched.sv
// rtl/bck_ctx_sched.sv - multi-context scheduler interleaving backward-extension tokens into stage 1
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   stall                    : freezes issue outputs and issue-driven state changes
//   start_*                  : new read request; start_ready = a context is IDLE
//   fb_*                     : end-of-iteration feedback for context fb_slot
//   issue_*                  : registered token (status, slot, read id, bx, size)
//   done_valid/done_read_num : one-cycle pulse when a context issues BCK_END
//   active_cnt               : number of non-IDLE contexts after the current edge
//   err_fb                   : sticky, feedback arrived for a context not waiting on it
module bck_ctx_sched
    import bck_pkg::*;
#(
    parameter int NUM_CTX = 4,
    parameter int CTX_W   = $clog2(NUM_CTX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [8:0]       start_read_num,
    input  logic [6:0]       start_backward_x,
    input  logic [6:0]       start_forward_size_n,
    input  logic             fb_valid,
    input  logic [CTX_W-1:0] fb_slot,
    input  logic [6:0]       fb_new_size,
    input  logic [6:0]       fb_backward_i,
    output logic [5:0]       issue_status,
    output logic [CTX_W-1:0] issue_slot,
    output logic [8:0]       issue_read_num,
    output logic [6:0]       issue_backward_x,
    output logic [6:0]       issue_forward_size_n,
    output logic             done_valid,
    output logic [8:0]       done_read_num,
    output logic [CTX_W:0]   active_cnt,
    output logic             err_fb
);

    ctx_state_t st_q [NUM_CTX];
    ctx_state_t st_n [NUM_CTX];
    logic [8:0] rn_q [NUM_CTX];
    logic [8:0] rn_n [NUM_CTX];
    logic [6:0] bx_q [NUM_CTX];
    logic [6:0] bx_n [NUM_CTX];
    logic [6:0] sz_q [NUM_CTX];
    logic [6:0] sz_n [NUM_CTX];

    logic [CTX_W-1:0] rr_ptr;
    logic [NUM_CTX-1:0] idle_vec;
    logic [NUM_CTX-1:0] ready_vec;
    logic             free_found;
    logic [CTX_W-1:0] free_idx;
    logic             pick_found;
    logic [CTX_W-1:0] pick_idx;
    logic             fb_bad;
    logic [CTX_W:0]   cnt_n;

    always_comb begin
        idle_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            idle_vec[i]  = (st_q[i] == CS_IDLE);
            ready_vec[i] = is_ready(st_q[i]);
        end
    end

    // Allocation is fixed priority: lowest-index IDLE context wins.
    rr_pick #(.N(NUM_CTX), .W(CTX_W)) u_free_pick (
        .elig  (idle_vec),
        .ptr   ('0),
        .found (free_found),
        .idx   (free_idx)
    );

    rr_pick #(.N(NUM_CTX), .W(CTX_W)) u_issue_pick (
        .elig  (ready_vec),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign start_ready = free_found;

    // Start, feedback and issue act on disjoint states (IDLE, WAIT_FB, RDY_*),
    // so applying them in sequence never lets one overwrite another.
    always_comb begin
        for (int i = 0; i < NUM_CTX; i++) begin
            st_n[i] = st_q[i];
            rn_n[i] = rn_q[i];
            bx_n[i] = bx_q[i];
            sz_n[i] = sz_q[i];
        end
        fb_bad = 1'b0;
        cnt_n  = '0;

        if (start_valid && free_found) begin
            st_n[free_idx] = CS_RDY_INI;
            rn_n[free_idx] = start_read_num;
            bx_n[free_idx] = start_backward_x;
            sz_n[free_idx] = start_forward_size_n;
        end

        if (fb_valid) begin
            if (st_q[fb_slot] == CS_WAIT_FB) begin
                if ((fb_new_size == 7'd0) || (fb_backward_i == 7'd0)) begin
                    st_n[fb_slot] = CS_RDY_END;
                end else begin
                    st_n[fb_slot] = CS_RDY_RUN;
                    sz_n[fb_slot] = fb_new_size;
                    bx_n[fb_slot] = fb_backward_i;
                end
            end else begin
                fb_bad = 1'b1;
            end
        end

        if (!stall && pick_found) begin
            if (st_q[pick_idx] == CS_RDY_END) begin
                st_n[pick_idx] = CS_IDLE;
            end else begin
                st_n[pick_idx] = CS_WAIT_FB;
            end
        end

        for (int i = 0; i < NUM_CTX; i++) begin
            if (st_n[i] != CS_IDLE) begin
                cnt_n = cnt_n + (CTX_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                st_q[i] <= CS_IDLE;
                rn_q[i] <= '0;
                bx_q[i] <= '0;
                sz_q[i] <= '0;
            end
            rr_ptr               <= '0;
            issue_status         <= BUBBLE;
            issue_slot           <= '0;
            issue_read_num       <= '0;
            issue_backward_x     <= '0;
            issue_forward_size_n <= '0;
            done_valid           <= 1'b0;
            done_read_num        <= '0;
            active_cnt           <= '0;
            err_fb               <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CTX; i++) begin
                st_q[i] <= st_n[i];
                rn_q[i] <= rn_n[i];
                bx_q[i] <= bx_n[i];
                sz_q[i] <= sz_n[i];
            end
            active_cnt <= cnt_n;
            if (fb_bad) begin
                err_fb <= 1'b1;
            end

            if (stall) begin
                done_valid <= 1'b0;
            end else if (pick_found) begin
                issue_status         <= token_of(st_q[pick_idx]);
                issue_slot           <= pick_idx;
                issue_read_num       <= rn_q[pick_idx];
                issue_backward_x     <= bx_q[pick_idx];
                issue_forward_size_n <= sz_q[pick_idx];
                rr_ptr               <= pick_idx + CTX_W'(1);
                done_valid           <= (st_q[pick_idx] == CS_RDY_END);
                if (st_q[pick_idx] == CS_RDY_END) begin
                    done_read_num <= rn_q[pick_idx];
                end
            end else begin
                issue_status         <= BUBBLE;
                issue_slot           <= '0;
                issue_read_num       <= '0;
                issue_backward_x     <= '0;
                issue_forward_size_n <= '0;
                done_valid           <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bck_ctx_sched.sv
// tb/tb_bck_ctx_sched.sv - self-checking bench for bck_ctx_sched
module tb_bck_ctx_sched;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic         start_valid;
    logic         start_ready;
    logic [8:0]   start_read_num;
    logic [6:0]   start_backward_x;
    logic [6:0]   start_forward_size_n;
    logic         fb_valid;
    logic [W-1:0] fb_slot;
    logic [6:0]   fb_new_size;
    logic [6:0]   fb_backward_i;
    logic [5:0]   issue_status;
    logic [W-1:0] issue_slot;
    logic [8:0]   issue_read_num;
    logic [6:0]   issue_backward_x;
    logic [6:0]   issue_forward_size_n;
    logic         done_valid;
    logic [8:0]   done_read_num;
    logic [W:0]   active_cnt;
    logic         err_fb;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bck_ctx_sched #(.NUM_CTX(N), .CTX_W(W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall                (stall),
        .start_valid          (start_valid),
        .start_ready          (start_ready),
        .start_read_num       (start_read_num),
        .start_backward_x     (start_backward_x),
        .start_forward_size_n (start_forward_size_n),
        .fb_valid             (fb_valid),
        .fb_slot              (fb_slot),
        .fb_new_size          (fb_new_size),
        .fb_backward_i        (fb_backward_i),
        .issue_status         (issue_status),
        .issue_slot           (issue_slot),
        .issue_read_num       (issue_read_num),
        .issue_backward_x     (issue_backward_x),
        .issue_forward_size_n (issue_forward_size_n),
        .done_valid           (done_valid),
        .done_read_num        (done_read_num),
        .active_cnt           (active_cnt),
        .err_fb               (err_fb)
    );

    // ---------------- reference model (per-read lifecycle, integer modes) ----------------
    localparam int M_IDLE = 0, M_INI = 1, M_WAIT = 2, M_RUN = 3, M_END = 4;
    int         m_st [N];
    logic [8:0] m_rn [N];
    logic [6:0] m_bx [N];
    logic [6:0] m_sz [N];
    int         m_ptr;
    logic [5:0] e_status;
    int         e_slot;
    logic [8:0] e_rn;
    logic [6:0] e_bx;
    logic [6:0] e_sz;
    bit         e_done;
    logic [8:0] e_done_rn;
    int         e_act;
    bit         e_err;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_st[k] = M_IDLE; m_rn[k] = 0; m_bx[k] = 0; m_sz[k] = 0;
        end
        m_ptr = 0; e_status = 6'h30; e_slot = 0; e_rn = 0; e_bx = 0; e_sz = 0;
        e_done = 0; e_done_rn = 0; e_act = 0; e_err = 0;
    endtask

    task automatic model_step(input bit sv, input logic [8:0] srn, input logic [6:0] sbx,
                              input logic [6:0] ssz, input bit fv, input int fs,
                              input logic [6:0] fns, input logic [6:0] fbi, input bit stl);
        int         nst [N];
        logic [8:0] nrn [N];
        logic [6:0] nbx [N];
        logic [6:0] nsz [N];
        bit         placed;
        int         pick;
        for (int k = 0; k < N; k++) begin
            nst[k] = m_st[k]; nrn[k] = m_rn[k]; nbx[k] = m_bx[k]; nsz[k] = m_sz[k];
        end
        placed = 0;
        if (sv) begin
            for (int k = 0; k < N; k++) begin
                if (!placed && m_st[k] == M_IDLE) begin
                    placed = 1; nst[k] = M_INI; nrn[k] = srn; nbx[k] = sbx; nsz[k] = ssz;
                end
            end
        end
        if (fv) begin
            if (m_st[fs] != M_WAIT) e_err = 1;
            else if (fns == 0 || fbi == 0) nst[fs] = M_END;
            else begin nst[fs] = M_RUN; nsz[fs] = fns; nbx[fs] = fbi; end
        end
        if (stl) begin
            e_done = 0;
        end else begin
            pick = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (pick < 0 && (m_st[c] == M_INI || m_st[c] == M_RUN || m_st[c] == M_END)) pick = c;
            end
            if (pick < 0) begin
                e_status = 6'h30; e_slot = 0; e_rn = 0; e_bx = 0; e_sz = 0; e_done = 0;
            end else begin
                e_status = (m_st[pick] == M_INI) ? 6'h04 : (m_st[pick] == M_RUN) ? 6'h05 : 6'h06;
                e_slot = pick; e_rn = m_rn[pick]; e_bx = m_bx[pick]; e_sz = m_sz[pick];
                m_ptr = (pick + 1) % N;
                e_done = (m_st[pick] == M_END);
                if (e_done) e_done_rn = m_rn[pick];
                nst[pick] = e_done ? M_IDLE : M_WAIT;
            end
        end
        e_act = 0;
        for (int k = 0; k < N; k++) begin
            m_st[k] = nst[k]; m_rn[k] = nrn[k]; m_bx[k] = nbx[k]; m_sz[k] = nsz[k];
            if (nst[k] != M_IDLE) e_act++;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        stall = 0; start_valid = 0; start_read_num = 0; start_backward_x = 0;
        start_forward_size_n = 0; fb_valid = 0; fb_slot = 0; fb_new_size = 0; fb_backward_i = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fb(input int s, input int ns, input int bi);
        fb_valid = 1; fb_slot = W'(s); fb_new_size = 7'(ns); fb_backward_i = 7'(bi);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 0;
        step(); step();
        n_checks++;
        if ({issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n} !== {6'h30, 2'd0, 9'd0, 7'd0, 7'd0})
            $display("FAIL reset_issue got %h/%0d/%0d/%0d/%0d want 30/0/0/0/0", issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n);
        else n_pass++;
        n_checks++;
        if ({done_valid, done_read_num, active_cnt, err_fb, start_ready} !== {1'b0, 9'd0, 3'd0, 1'b0, 1'b1})
            $display("FAIL reset_misc got done=%b rn=%0d act=%0d err=%b rdy=%b want 0/0/0/0/1", done_valid, done_read_num, active_cnt, err_fb, start_ready);
        else n_pass++;
        rst = 1;
        step();
        n_checks++;
        if (issue_status !== 6'h30) $display("FAIL reset_idle_bubble got %h want 30", issue_status);
        else n_pass++;
    endtask

    task automatic test_single();
        start_valid = 1; start_read_num = 5; start_backward_x = 10; start_forward_size_n = 3;
        step();
        clear_inputs();
        n_checks++;
        if ({issue_status, active_cnt} !== {6'h30, 3'd1})
            $display("FAIL single_accept got st=%h act=%0d want 30/1", issue_status, active_cnt);
        else n_pass++;
        step();
        n_checks++;
        if ({issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n} !== {6'h04, 2'd0, 9'd5, 7'd10, 7'd3})
            $display("FAIL single_ini got %h/%0d/%0d/%0d/%0d want 04/0/5/10/3", issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n);
        else n_pass++;
        step();
        n_checks++;
        if (issue_status !== 6'h30) $display("FAIL single_wait_bubble got %h want 30", issue_status);
        else n_pass++;
        drive_fb(0, 2, 9);
        step();
        clear_inputs();
        step();
        n_checks++;
        if ({issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n} !== {6'h05, 2'd0, 9'd5, 7'd9, 7'd2})
            $display("FAIL single_run got %h/%0d/%0d/%0d/%0d want 05/0/5/9/2", issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n);
        else n_pass++;
        drive_fb(0, 0, 9);
        step();
        clear_inputs();
        step();
        n_checks++;
        if ({issue_status, issue_slot, done_valid, done_read_num, active_cnt} !== {6'h06, 2'd0, 1'b1, 9'd5, 3'd0})
            $display("FAIL single_end got st=%h slot=%0d done=%b rn=%0d act=%0d want 06/0/1/5/0", issue_status, issue_slot, done_valid, done_read_num, active_cnt);
        else n_pass++;
        step();
        n_checks++;
        if (done_valid !== 1'b0) $display("FAIL single_done_pulse got %b want 0", done_valid);
        else n_pass++;
    endtask

    task automatic test_four_starts();
        for (int i = 0; i < 4; i++) begin
            start_valid = 1; start_read_num = 9'(20 + i);
            start_backward_x = 7'(40 + i); start_forward_size_n = 7'(1 + i);
            step();
            n_checks++;
            if (i == 0) begin
                if (issue_status !== 6'h30) $display("FAIL four_first got %h want 30", issue_status);
                else n_pass++;
            end else begin
                if ({issue_status, issue_slot, issue_read_num} !== {6'h04, 2'(i - 1), 9'(19 + i)})
                    $display("FAIL four_ini%0d got %h/%0d/%0d want 04/%0d/%0d", i, issue_status, issue_slot, issue_read_num, i - 1, 19 + i);
                else n_pass++;
            end
            n_checks++;
            if (start_ready !== (i < 3)) $display("FAIL four_ready%0d got %b want %b", i, start_ready, i < 3);
            else n_pass++;
        end
        clear_inputs();
        n_checks++;
        if (active_cnt !== 3'd4) $display("FAIL four_active got %0d want 4", active_cnt);
        else n_pass++;
        step();
        n_checks++;
        if ({issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n} !== {6'h04, 2'd3, 9'd23, 7'd43, 7'd4})
            $display("FAIL four_ini3 got %h/%0d/%0d/%0d/%0d want 04/3/23/43/4", issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            drive_fb(i, 10 + i, 30 + i);
            step();
        end
        n_checks++;
        if ({issue_status, issue_slot} !== {6'h04, 2'd3})
            $display("FAIL rr_stall_hold got %h/%0d want 04/3", issue_status, issue_slot);
        else n_pass++;
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            if (k == 1) drive_fb(0, 50, 60);
            step();
            clear_inputs();
            n_checks++;
            if ({issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n} !== {6'h05, 2'(k), 9'(20 + k), 7'(30 + k), 7'(10 + k)})
                $display("FAIL rr_order%0d got %h/%0d/%0d/%0d/%0d want 05/%0d/%0d/%0d/%0d", k, issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n, k, 20 + k, 30 + k, 10 + k);
            else n_pass++;
        end
        step();
        n_checks++;
        if ({issue_status, issue_slot, issue_backward_x, issue_forward_size_n, err_fb} !== {6'h05, 2'd0, 7'd60, 7'd50, 1'b0})
            $display("FAIL rr_wrap got %h/%0d/%0d/%0d err=%b want 05/0/60/50/0", issue_status, issue_slot, issue_backward_x, issue_forward_size_n, err_fb);
        else n_pass++;
    endtask

    task automatic test_end_done();
        drive_fb(2, 0, 7);
        step();
        clear_inputs();
        n_checks++;
        if ({issue_status, start_ready} !== {6'h30, 1'b0})
            $display("FAIL end_pre got st=%h rdy=%b want 30/0", issue_status, start_ready);
        else n_pass++;
        step();
        n_checks++;
        if ({issue_status, issue_slot, done_valid, done_read_num, start_ready, active_cnt} !== {6'h06, 2'd2, 1'b1, 9'd22, 1'b1, 3'd3})
            $display("FAIL end_done got st=%h slot=%0d done=%b rn=%0d rdy=%b act=%0d want 06/2/1/22/1/3", issue_status, issue_slot, done_valid, done_read_num, start_ready, active_cnt);
        else n_pass++;
        step();
        n_checks++;
        if ({issue_status, done_valid} !== {6'h30, 1'b0})
            $display("FAIL end_after got st=%h done=%b want 30/0", issue_status, done_valid);
        else n_pass++;
    endtask

    task automatic test_stall();
        drive_fb(3, 5, 8);
        step();
        clear_inputs();
        step();
        n_checks++;
        if ({issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n} !== {6'h05, 2'd3, 9'd23, 7'd8, 7'd5})
            $display("FAIL stall_pre got %h/%0d/%0d/%0d/%0d want 05/3/23/8/5", issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n);
        else n_pass++;
        for (int j = 0; j < 3; j++) begin
            stall = 1;
            if (j == 0) drive_fb(1, 4, 6);
            if (j == 1) drive_fb(0, 0, 1);
            step();
            clear_inputs();
            n_checks++;
            if ({issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n, done_valid} !== {6'h05, 2'd3, 9'd23, 7'd8, 7'd5, 1'b0})
                $display("FAIL stall_hold%0d got %h/%0d/%0d/%0d/%0d done=%b want 05/3/23/8/5/0", j, issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n, done_valid);
            else n_pass++;
        end
        step();
        n_checks++;
        if ({issue_status, issue_slot, done_valid, done_read_num} !== {6'h06, 2'd0, 1'b1, 9'd20})
            $display("FAIL stall_release_end got st=%h slot=%0d done=%b rn=%0d want 06/0/1/20", issue_status, issue_slot, done_valid, done_read_num);
        else n_pass++;
        step();
        n_checks++;
        if ({issue_status, issue_slot, issue_backward_x, issue_forward_size_n, done_valid, active_cnt} !== {6'h05, 2'd1, 7'd6, 7'd4, 1'b0, 3'd2})
            $display("FAIL stall_release_run got %h/%0d/%0d/%0d done=%b act=%0d want 05/1/6/4/0/2", issue_status, issue_slot, issue_backward_x, issue_forward_size_n, done_valid, active_cnt);
        else n_pass++;
    endtask

    task automatic test_err_and_reset();
        drive_fb(2, 3, 3);
        step();
        clear_inputs();
        n_checks++;
        if ({err_fb, active_cnt, issue_status} !== {1'b1, 3'd2, 6'h30})
            $display("FAIL err_fb got err=%b act=%0d st=%h want 1/2/30", err_fb, active_cnt, issue_status);
        else n_pass++;
        step();
        n_checks++;
        if ({err_fb, issue_status} !== {1'b1, 6'h30}) $display("FAIL err_sticky got err=%b st=%h want 1/30", err_fb, issue_status);
        else n_pass++;
        rst = 0;
        step();
        n_checks++;
        if ({issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n, done_valid, done_read_num, active_cnt, err_fb, start_ready}
            !== {6'h30, 2'd0, 9'd0, 7'd0, 7'd0, 1'b0, 9'd0, 3'd0, 1'b0, 1'b1})
            $display("FAIL midrun_reset got st=%h act=%0d err=%b done=%b drn=%0d rdy=%b", issue_status, active_cnt, err_fb, done_valid, done_read_num, start_ready);
        else n_pass++;
        rst = 1;
        step();
        n_checks++;
        if ({issue_status, active_cnt, done_valid} !== {6'h30, 3'd0, 1'b0})
            $display("FAIL post_reset got st=%h act=%0d done=%b want 30/0/0", issue_status, active_cnt, done_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        clear_inputs();
        rst = 0;
        step();
        rst = 1;
        model_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_checks++;
            if (start_ready !== (m_st[0] == M_IDLE || m_st[1] == M_IDLE || m_st[2] == M_IDLE || m_st[3] == M_IDLE))
                $display("FAIL rnd_ready cyc%0d got %b", cyc, start_ready);
            else n_pass++;
            stall                = ($urandom_range(0, 4) == 0);
            start_valid          = ($urandom_range(0, 2) == 0);
            start_read_num       = 9'($urandom);
            start_backward_x     = 7'($urandom);
            start_forward_size_n = 7'($urandom);
            fb_valid             = ($urandom_range(0, 1) == 0);
            fb_slot              = W'($urandom_range(0, N - 1));
            fb_new_size          = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            fb_backward_i        = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            model_step(start_valid, start_read_num, start_backward_x, start_forward_size_n,
                       fb_valid, int'(fb_slot), fb_new_size, fb_backward_i, stall);
            step();
            n_checks++;
            if ({issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n} !== {e_status, 2'(e_slot), e_rn, e_bx, e_sz})
                $display("FAIL rnd_issue cyc%0d got %h/%0d/%0d/%0d/%0d want %h/%0d/%0d/%0d/%0d", cyc, issue_status, issue_slot, issue_read_num, issue_backward_x, issue_forward_size_n, e_status, e_slot, e_rn, e_bx, e_sz);
            else n_pass++;
            n_checks++;
            if (done_valid !== e_done || (e_done && done_read_num !== e_done_rn))
                $display("FAIL rnd_done cyc%0d got %b/%0d want %b/%0d", cyc, done_valid, done_read_num, e_done, e_done_rn);
            else n_pass++;
            n_checks++;
            if ({active_cnt, err_fb} !== {3'(e_act), e_err})
                $display("FAIL rnd_cnt_err cyc%0d got act=%0d err=%b want %0d/%b", cyc, active_cnt, err_fb, e_act, e_err);
            else n_pass++;
        end
        clear_inputs();
    endtask

    initial begin
        rst = 0;
        clear_inputs();
        test_reset();
        test_single();
        test_four_starts();
        test_round_robin();
        test_end_done();
        test_stall();
        test_err_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
